// File: rtl/sw_pkg.sv
// Shared types for the switch configuration sequencer: chain word layouts and FSM states.
package sw_pkg;

  localparam int COUNT_W = 4;

  typedef struct packed {
    logic [COUNT_W-1:0] count;
    logic               enable;
    logic [1:0]         port_num;
    logic [1:0]         src;
  } cfg_entry_t;

  typedef struct packed {
    logic               valid;
    logic [COUNT_W-1:0] count;
    logic               enable;
    logic [1:0]         port_num;
    logic [1:0]         src;
  } sw_config_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/sw_cfg_table.sv
// Routing entry table: one synchronous write port, one combinational read port, no reset.
module sw_cfg_table
  import sw_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  cfg_entry_t               i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output cfg_entry_t               o_rdata
);

  cfg_entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/switch_cfg_sequencer.sv
// Streams preloaded routing entries into the head of the switch config chain, then waits
// for the farthest entry to land before pulsing done.
//   state | meaning
//   IDLE  | table writable, waiting for start
//   ISSUE | one table entry per cycle onto the chain (illegal hop counts skipped)
//   DRAIN | chain idle while the farthest entry propagates
//   FIN   | one-cycle done pulse, busy drops
module switch_cfg_sequencer
  import sw_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CHAIN_LEN = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  cfg_entry_t               i_wr_data,
  output logic                     o_wr_err,
  input  logic                     i_start,
  input  logic [$clog2(DEPTH):0]   i_num_entries,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_cfg_err,
  output sw_config_t               o_sw_config_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [COUNT_W:0] CHAIN_LIM = (COUNT_W+1)'(CHAIN_LEN);
  localparam logic [AW:0]      DEPTH_LIM = (AW+1)'(DEPTH);

  state_e             r_state;
  logic [AW-1:0]      r_ptr;
  logic [AW-1:0]      r_last;
  logic [COUNT_W-1:0] r_max;
  logic [COUNT_W:0]   r_drain;
  sw_config_t         r_cfg;
  logic               r_busy;
  logic               r_done;
  logic               r_wr_err;
  logic               r_cfg_err;

  cfg_entry_t         w_entry;
  logic               w_table_we;
  logic               w_legal;
  logic [COUNT_W-1:0] w_max_next;
  logic [AW-1:0]      w_last;

  assign w_table_we = i_wr_en && (r_state == IDLE);

  sw_cfg_table #(.DEPTH(DEPTH)) u_table (
    .i_clk   (i_clk),
    .i_we    (w_table_we),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data),
    .i_raddr (r_ptr),
    .o_rdata (w_entry)
  );

  assign w_legal    = {1'b0, w_entry.count} < CHAIN_LIM;
  assign w_max_next = (w_legal && (w_entry.count > r_max)) ? w_entry.count : r_max;
  // Requests beyond the table size are clamped; zero is handled by skipping ISSUE.
  assign w_last     = (i_num_entries > DEPTH_LIM) ? AW'(DEPTH - 1)
                                                  : AW'(i_num_entries - (AW+1)'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_last    <= '0;
      r_max     <= '0;
      r_drain   <= '0;
      r_cfg     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_err  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_wr_err <= i_wr_en && (r_state != IDLE);
      r_done   <= 1'b0;
      r_cfg    <= '0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_ptr     <= '0;
            r_max     <= '0;
            r_last    <= w_last;
            r_cfg_err <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= (i_num_entries == '0) ? FIN : ISSUE;
          end
        end
        ISSUE: begin
          if (w_legal) r_cfg <= {1'b1, w_entry};
          else         r_cfg_err <= 1'b1;
          r_max <= w_max_next;
          r_ptr <= r_ptr + AW'(1);
          if (r_ptr == r_last) begin
            r_drain <= {1'b0, w_max_next} + (COUNT_W+1)'(1);
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_drain <= r_drain - (COUNT_W+1)'(1);
          if (r_drain == (COUNT_W+1)'(1)) r_state <= FIN;
        end
        FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sw_config_out = r_cfg;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_wr_err        = r_wr_err;
  assign o_cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_switch_cfg_sequencer.sv
// Scoreboard bench for switch_cfg_sequencer: directed runs push expected chain words,
// a negedge monitor pops and compares every valid word the DUT presents.
module tb_switch_cfg_sequencer;
  import sw_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [3:0] i_wr_addr = '0;
  cfg_entry_t i_wr_data = '0;
  logic       i_start = 1'b0;
  logic [4:0] i_num_entries = '0;
  logic       o_wr_err, o_busy, o_done, o_cfg_err;
  sw_config_t o_sw_config_out;

  switch_cfg_sequencer #(.DEPTH(16), .CHAIN_LEN(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_en         (i_wr_en),
    .i_wr_addr       (i_wr_addr),
    .i_wr_data       (i_wr_data),
    .o_wr_err        (o_wr_err),
    .i_start         (i_start),
    .i_num_entries   (i_num_entries),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_cfg_err       (o_cfg_err),
    .o_sw_config_out (o_sw_config_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    sw_config_t cfg;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  cfg_entry_t tb_mem[16];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_done = 0;
  int         n_wrerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_done)   n_done++;
      if (o_wr_err) n_wrerr++;
      if (o_sw_config_out.valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cfg", 32'(o_sw_config_out), 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("cfg_word", 32'(o_sw_config_out), 32'(mon_e.cfg));
          check("cfg_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  function automatic cfg_entry_t mk(input logic [3:0] c, input logic e,
                                    input logic [1:0] p, input logic [1:0] s);
    cfg_entry_t x;
    x.count = c; x.enable = e; x.port_num = p; x.src = s;
    return x;
  endfunction

  task automatic write_entry(input logic [3:0] a, input cfg_entry_t d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    @(negedge clk);
    i_wr_en = 1'b0;
    tb_mem[a] = d;
  endtask

  // Returns at the negedge after the accepting edge, with cyc == t.
  task automatic do_start(input logic [4:0] n, output int t);
    int lim;
    t   = cyc + 1;
    lim = (n > 5'd16) ? 16 : int'(n);
    for (int k = 0; k < lim; k++)
      if (tb_mem[k].count < 4'd8)
        exp_q.push_back('{cyc: t + 1 + k, cfg: {1'b1, tb_mem[k]}});
    i_start = 1'b1; i_num_entries = n;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_done) begin seen = 1'b1; break; end
    end
    if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      check(nm, cyc, exp_cyc);
      check({nm, "_busy_low"}, 32'(o_busy), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_cfg"},     32'(o_sw_config_out), 32'h0);
    check({nm, "_busy"},    32'(o_busy),    32'd0);
    check({nm, "_done"},    32'(o_done),    32'd0);
    check({nm, "_wr_err"},  32'(o_wr_err),  32'd0);
    check({nm, "_cfg_err"}, 32'(o_cfg_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d0, w0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic three-entry run: max_count=2, done at T+7.
    write_entry(4'd0, mk(4'd0, 1'b1, 2'd0, 2'd2));
    write_entry(4'd1, mk(4'd2, 1'b1, 2'd3, 2'd1));
    write_entry(4'd2, mk(4'd1, 1'b0, 2'd1, 2'd0));
    do_start(5'd3, t);
    check("run1_busy_T", 32'(o_busy), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k < 7) begin
        check("run1_busy", 32'(o_busy), 32'd1);
        check("run1_done_early", 32'(o_done), 32'd0);
      end else begin
        check("run1_done_T7", 32'(o_done), 32'd1);
        check("run1_busy_end", 32'(o_busy), 32'd0);
      end
    end
    check("run1_cfg_err", 32'(o_cfg_err), 32'd0);
    check("run1_q_empty", exp_q.size(), 0);

    // Illegal hop count at address 1 is skipped; max_count=1, done at T+6.
    write_entry(4'd1, mk(4'd9, 1'b1, 2'd2, 2'd3));
    do_start(5'd3, t);
    @(negedge clk);
    @(negedge clk);
    check("skip_valid_low", 32'(o_sw_config_out.valid), 32'd0);
    check("skip_cfg_err_set", 32'(o_cfg_err), 32'd1);
    wait_done(t + 6, "skip_done");
    repeat (3) @(negedge clk);
    check("skip_cfg_err_sticky", 32'(o_cfg_err), 32'd1);
    check("skip_q_empty", exp_q.size(), 0);

    // Zero entries: one busy cycle, then done; cfg_err cleared by the start.
    do_start(5'd0, t);
    check("zero_busy", 32'(o_busy), 32'd1);
    check("zero_cfg_err_clr", 32'(o_cfg_err), 32'd0);
    @(negedge clk);
    check("zero_done", 32'(o_done), 32'd1);
    check("zero_busy_end", 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);

    // Write and start while issuing: both rejected/ignored. max_count=3, done at T+8.
    write_entry(4'd1, mk(4'd3, 1'b1, 2'd2, 2'd3));
    d0 = n_done; w0 = n_wrerr;
    do_start(5'd3, t);
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_data = mk(4'd7, 1'b0, 2'd3, 2'd3);
    i_start = 1'b1; i_num_entries = 5'd16;
    @(negedge clk);
    i_wr_en = 1'b0; i_start = 1'b0;
    check("busy_wr_err_pulse", 32'(o_wr_err), 32'd1);
    wait_done(t + 8, "busy_done");
    repeat (10) @(negedge clk);
    check("busy_one_done", n_done - d0, 1);
    check("busy_one_wr_err", n_wrerr - w0, 1);
    check("busy_q_empty", exp_q.size(), 0);
    do_start(5'd1, t);
    wait_done(t + 3, "recheck_done");
    check("recheck_q_empty", exp_q.size(), 0);

    // num_entries=31 clamps to 16; max_count=7, done at T+25.
    for (int k = 0; k < 16; k++)
      write_entry(4'(k), mk(4'(k % 8), 1'(k % 2), 2'((k / 2) % 4), 2'(k % 4)));
    do_start(5'd31, t);
    wait_done(t + 25, "clamp_done");
    check("clamp_q_empty", exp_q.size(), 0);
    check("clamp_cfg_err", 32'(o_cfg_err), 32'd0);

    // Reset mid-run after entries 0 and 1, then a fresh run from entry 0.
    do_start(5'd4, t);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst_async");
    @(negedge clk);
    check_all_zero("midrst_held");
    check("midrst_pending", exp_q.size(), 2);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    do_start(5'd4, t);
    wait_done(t + 9, "rerun_done");
    check("rerun_q_empty", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
